bitcoin_hash_multi: RTL and testbench
=====================================

Name: bitcoin_hash_multi

Overview:
- Parametrised bitcoin nonce-search engine. Reads one 19-word block-header prefix from word-addressed memory.
- Computes the phase-1 midstate once. For each of NUM_NONCES consecutive nonces starting at nonce_base, it runs phase 2 (second header block) and phase 3 (SHA-256 of the 256-bit digest).
- After each nonce completes, it streams that nonce's final H0 word to memory.
- Sits on the shared single-port testbench memory, beside the SHA-256 and plain bitcoin hash blocks.

Parameters:
- NUM_NONCES, 16, number of nonces hashed per run (1..65535).
- OUT_STRIDE, 1, word stride between successive output writes (1..16).

Ports:
- clk  in  1  clock; also drives mem_clk.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE only.
- message_addr  in  16  word address of header word 0.
- output_addr  in  16  word address of first result.
- nonce_base  in  32  first nonce value; sampled on accepted start.
- done  out  1  run complete; held high until next accepted start.
- busy  out  1  high from accepted start until done rises.
- mem_clk  out  1  equals clk.
- mem_we  out  1  write enable.
- mem_addr  out  16  memory address.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  read data, valid the cycle after mem_addr is presented.

Behaviour:
- Reset values: done=0, busy=0, mem_we=0, mem_addr=0, mem_write_data=0; FSM in IDLE.
- Reset is asynchronous and may arrive mid-run. The run is abandoned and no further writes occur.
- FSM states: IDLE -> READ -> P1 -> P2 -> P3 -> WR -> (P2 | DONE) -> IDLE.
- IDLE:
  - start=1 latches message_addr, output_addr and nonce_base, clears done, sets busy, and sets nonce index i=0.
  - start while busy is ignored.
- READ:
  - Issues addresses message_addr..message_addr+18 on consecutive cycles with mem_we=0.
  - Captures 19 words with one-cycle read latency.
  - Words 0..15 form the block-1 schedule; words 16..18 go to a 3-entry header tail register.
- P1: compresses block 1 with the standard IV. Result is stored as midstate[0..7]. Runs once per run.
- P2:
  - Schedule is {tail0, tail1, tail2, nonce_base+i, 32'h80000000, ten zeros, 32'd640}.
  - Chaining input is midstate.
  - Nonce addition wraps mod 2^32.
- P3: schedule is {P2 digest[0..7], 32'h80000000, six zeros, 32'd256}, with the standard IV.
- WR:
  - One cycle: mem_we=1, mem_addr=output_addr+i*OUT_STRIDE (mod 2^16), mem_write_data=P3 H0.
  - The next cycle mem_we returns to 0.
  - If i==NUM_NONCES-1, go to DONE; else i++ and return to P2.
- DONE: done=1, busy=0, return to IDLE.
- Compression latency: each phase uses sha256_block. Its done pulse comes exactly 65 cycles after the start pulse (64 rounds plus 1 feed-forward add).
- Message schedule: 16-word sliding window computing W[t] on the fly. No 64-word array.
- mem_we is high only in WR cycles. Exactly NUM_NONCES writes per run.
- No per-nonce result buffering; each result is written as soon as it is produced.

Optional Feature:
- Macro: BITCOIN_TARGET_EN.
- Defined: adds ports target (in, 32), found (out, 1) and found_nonce (out, 32); both outputs reset to 0 and clear on accepted start.
  - On the first nonce whose P3 H0 < target (unsigned), its WR still occurs, then found=1 and found_nonce=nonce_base+i are latched.
  - The FSM then goes directly to DONE; remaining nonces are skipped.
- Undefined: these ports are absent and all NUM_NONCES nonces are always processed.

Decomposition:
- Package bitcoin_pkg holds:
  - K[0:63] constant array and IV[0:7] constants;
  - state enum type;
  - functions rotr, big/small sigma0/1, ch, maj.
- Sub-module sha256_block owns the compression (one sequential instance, reused for P1/P2/P3).
  - Inputs: clk, reset_n, start, h_in[8], w_in[16].
  - Outputs: done, h_out[8].

Test Plan:
- sha256_block unit: padded "abc" block (w0=32'h61626380, w15=32'h18), IV -> done exactly 65 cycles after start; h_out[0]=32'hba7816bf, h_out[7]=32'hf20015ad.
- Full run, NUM_NONCES=16, nonce_base=0, message_addr=0, output_addr=16'h0100 -> 19 reads at 0..18; 16 writes to 0x0100..0x010F matching golden model; done high and held.
- OUT_STRIDE=4, NUM_NONCES=3, output_addr=16'hFFF8 -> writes at 0xFFF8, 0xFFFC, 0x0000 (address wrap).
- nonce_base=32'hFFFFFFFF, NUM_NONCES=2 -> hashed nonces are 0xFFFFFFFF and 0x00000000; results match model.
- Assert reset_n low during P2 of nonce 5 -> done=0, busy=0, mem_we=0 immediately, no further writes. A following start completes a correct full run.
- BITCOIN_TARGET_EN, target=32'hFFFFFFFF -> found=1 and found_nonce=nonce_base after a single write; with target=0, all NUM_NONCES writes occur and found=0.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg
// Shared SHA-256 definitions for the bitcoin nonce-search engine:
//   - K[0:63] round constants and IV[0:7] initial hash value
//   - state_t FSM encoding for bitcoin_hash_multi
//   - hash_t (8 words) and block_t (16 words) packed types, word 0 at the LSB
//   - rotr / sigma / ch / maj helper functions
package bitcoin_pkg;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_P1, S_P2, S_P3, S_WR, S_DONE} state_t;

  typedef logic [7:0][31:0]  hash_t;
  typedef logic [15:0][31:0] block_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic hash_t ivHash();
    hash_t h;
    for (int i = 0; i < 8; i++) h[i] = IV[i];
    return h;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bigSigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bigSigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] smallSigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] smallSigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_block.sv
// sha256_block
// One SHA-256 compression of a 16-word block, one round per cycle.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          one-cycle pulse; h_in and w_in are sampled on this cycle
//   h_in           chaining input (word 0 at LSB)
//   w_in           message block (word 0 at LSB)
//   done           one-cycle pulse 65 cycles after start
//   h_out          h_in + compressed state; held until the next completion
module sha256_block
  import bitcoin_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   start,
  input  hash_t  h_in,
  input  block_t w_in,
  output logic   done,
  output hash_t  h_out
);

  hash_t      r_hin, r_state, r_hout;
  block_t     r_win;
  logic [5:0] r_t;
  logic       r_active, r_ff, r_done;

  hash_t       w_cur, w_next;
  block_t      w_win;
  logic [5:0]  w_t;
  logic [31:0] w_t1, w_t2, w_new;

  // Round 0 is computed straight from the inputs on the start cycle, so the
  // 64 rounds occupy start..start+63 and the feed-forward lands on cycle 64.
  // The schedule is a 16-word window: word 0 is W[t], and the word shifted in
  // at the top is W[t+16].
  always_comb begin
    w_cur  = start ? h_in : r_state;
    w_win  = start ? w_in : r_win;
    w_t    = start ? 6'd0 : r_t;
    w_t1   = w_cur[7] + bigSigma1(w_cur[4]) + ch(w_cur[4], w_cur[5], w_cur[6]) + K[w_t] + w_win[0];
    w_t2   = bigSigma0(w_cur[0]) + maj(w_cur[0], w_cur[1], w_cur[2]);
    w_next = {w_cur[6:4], w_cur[3] + w_t1, w_cur[2:0], w_t1 + w_t2};
    w_new  = smallSigma1(w_win[14]) + w_win[9] + smallSigma0(w_win[1]) + w_win[0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hin    <= '0;
      r_state  <= '0;
      r_hout   <= '0;
      r_win    <= '0;
      r_t      <= '0;
      r_active <= 1'b0;
      r_ff     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_hin    <= h_in;
        r_state  <= w_next;
        r_win    <= {w_new, w_win[15:1]};
        r_t      <= 6'd1;
        r_active <= 1'b1;
        r_ff     <= 1'b0;
      end else if (r_active) begin
        r_state <= w_next;
        r_win   <= {w_new, w_win[15:1]};
        r_t     <= r_t + 6'd1;
        if (r_t == 6'd63) begin
          r_active <= 1'b0;
          r_ff     <= 1'b1;
        end
      end else if (r_ff) begin
        for (int i = 0; i < 8; i++) r_hout[i] <= r_hin[i] + r_state[i];
        r_done <= 1'b1;
        r_ff   <= 1'b0;
      end
    end
  end

  assign done  = r_done;
  assign h_out = r_hout;

endmodule

// File: rtl/bitcoin_hash_multi.sv
// bitcoin_hash_multi
// Nonce-search engine: reads a 19-word header prefix, computes the midstate
// once, then hashes NUM_NONCES consecutive nonces (double SHA-256) and writes
// each final H0 word to output_addr + i*OUT_STRIDE.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   start                              begin a run (accepted in IDLE only)
//   message_addr, output_addr          header / first-result word addresses
//   nonce_base                         first nonce
//   done, busy                         run status
//   mem_clk, mem_we, mem_addr,
//   mem_write_data, mem_read_data      single-port memory, 1-cycle read latency
// Optional (macro BITCOIN_TARGET_EN): target in, found / found_nonce out;
// the run stops after the first nonce whose H0 is below target.
module bitcoin_hash_multi
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int OUT_STRIDE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] nonce_base,
`ifdef BITCOIN_TARGET_EN
  input  logic [31:0] target,
  output logic        found,
  output logic [31:0] found_nonce,
`endif
  output logic        done,
  output logic        busy,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  state_t           r_state, w_nextState;
  logic [15:0]      r_msgAddr, r_wrAddr, r_idx;
  logic [31:0]      r_nonce;
  logic [4:0]       r_rdCnt;
  block_t           r_blk;
  logic [2:0][31:0] r_tail;
  hash_t            r_mid;
  logic             r_done, r_shaStart;

  logic             w_shaDone, w_lastNonce, w_hit;
  hash_t            w_shaOut, w_shaH;
  block_t           w_shaW;
  logic [4:0]       w_capIdx;

  assign mem_clk     = clk;
  assign done        = r_done;
  assign w_lastNonce = (r_idx == 16'(NUM_NONCES - 1));
  assign w_capIdx    = r_rdCnt - 5'd1;

`ifdef BITCOIN_TARGET_EN
  logic        r_found;
  logic [31:0] r_foundNonce;
  assign w_hit       = (w_shaOut[0] < target);
  assign found       = r_found;
  assign found_nonce = r_foundNonce;
`else
  assign w_hit = 1'b0;
`endif

  sha256_block u_sha (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (r_shaStart),
    .h_in   (w_shaH),
    .w_in   (w_shaW),
    .done   (w_shaDone),
    .h_out  (w_shaOut)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  // Next-state logic. READ spends one extra cycle so the last word, returned
  // with one cycle of latency, is captured before P1 starts.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_READ;
      S_READ:  if (r_rdCnt == 5'd19) w_nextState = S_P1;
      S_P1:    if (w_shaDone) w_nextState = S_P2;
      S_P2:    if (w_shaDone) w_nextState = S_P3;
      S_P3:    if (w_shaDone) w_nextState = S_WR;
      S_WR:    w_nextState = (w_lastNonce || w_hit) ? S_DONE : S_P2;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Outputs decoded from state, so an asynchronous reset drops them at once.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    busy           = (r_state != S_IDLE) && (r_state != S_DONE);
    case (r_state)
      S_READ: if (r_rdCnt < 5'd19) mem_addr = r_msgAddr + 16'(r_rdCnt);
      S_WR: begin
        mem_we         = 1'b1;
        mem_addr       = r_wrAddr;
        mem_write_data = w_shaOut[0];
      end
      default: ;
    endcase
  end

  // Compression inputs per phase. In P3 the block is the P2 digest still held
  // on h_out; it is only sampled on the start cycle.
  always_comb begin
    w_shaH = ivHash();
    w_shaW = r_blk;
    case (r_state)
      S_P2: begin
        w_shaH = r_mid;
        w_shaW = {32'd640, 320'd0, 32'h80000000, r_nonce, r_tail};
      end
      S_P3:    w_shaW = {32'd256, 192'd0, 32'h80000000, w_shaOut};
      default: ;
    endcase
  end

  // Datapath: header capture, midstate, running nonce and write address.
  // The compressor is started on the first cycle of each hashing phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msgAddr  <= '0;
      r_wrAddr   <= '0;
      r_idx      <= '0;
      r_nonce    <= '0;
      r_rdCnt    <= '0;
      r_blk      <= '0;
      r_tail     <= '0;
      r_mid      <= '0;
      r_done     <= 1'b0;
      r_shaStart <= 1'b0;
`ifdef BITCOIN_TARGET_EN
      r_found      <= 1'b0;
      r_foundNonce <= '0;
`endif
    end else begin
      r_shaStart <= (w_nextState != r_state) && (w_nextState inside {S_P1, S_P2, S_P3});
      if (w_nextState == S_DONE) r_done <= 1'b1;
      case (r_state)
        S_IDLE: if (start) begin
          r_msgAddr <= message_addr;
          r_wrAddr  <= output_addr;
          r_nonce   <= nonce_base;
          r_idx     <= '0;
          r_rdCnt   <= '0;
          r_done    <= 1'b0;
`ifdef BITCOIN_TARGET_EN
          r_found      <= 1'b0;
          r_foundNonce <= '0;
`endif
        end
        S_READ: begin
          r_rdCnt <= r_rdCnt + 5'd1;
          if (r_rdCnt != 5'd0) begin
            if (w_capIdx < 5'd16) r_blk[w_capIdx[3:0]]  <= mem_read_data;
            else                  r_tail[w_capIdx[1:0]] <= mem_read_data;
          end
        end
        S_P1: if (w_shaDone) r_mid <= w_shaOut;
        S_WR: begin
`ifdef BITCOIN_TARGET_EN
          if (w_hit) begin
            r_found      <= 1'b1;
            r_foundNonce <= r_nonce;
          end
`endif
          r_idx    <= r_idx + 16'd1;
          r_nonce  <= r_nonce + 32'd1;
          r_wrAddr <= r_wrAddr + 16'(OUT_STRIDE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_hash_multi.sv
module tb_bitcoin_hash_multi;
  import bitcoin_pkg::*;

  localparam logic [31:0] MK [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] MIV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] ABC [0:7] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223, 32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  logic        clk, reset_n;
  int          vectorCount = 0;
  int          missCount = 0;
  logic [31:0] hdr [19];

  logic        startA, doneA, busyA, memClkA, weA;
  logic [15:0] msgA, outA, addrA;
  logic [31:0] baseA, wdataA, rdataA;
  logic        startB, doneB, busyB, memClkB, weB;
  logic [15:0] msgB, outB, addrB;
  logic [31:0] baseB, wdataB, rdataB;
`ifdef BITCOIN_TARGET_EN
  logic [31:0] targetA, targetB, foundNonceA, foundNonceB;
  logic        foundA, foundB;
`endif

  logic        shaStart, shaDone;
  hash_t       shaH, shaOut;
  block_t      shaW;

  logic [15:0] logAddrA [$];
  logic [31:0] logDataA [$];
  logic [15:0] logAddrB [$];
  logic [31:0] logDataB [$];
  logic [15:0] offA, offB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bitcoin_hash_multi #(.NUM_NONCES(16), .OUT_STRIDE(1)) dutA (
    .clk(clk), .reset_n(reset_n), .start(startA), .message_addr(msgA), .output_addr(outA), .nonce_base(baseA),
`ifdef BITCOIN_TARGET_EN
    .target(targetA), .found(foundA), .found_nonce(foundNonceA),
`endif
    .done(doneA), .busy(busyA), .mem_clk(memClkA), .mem_we(weA), .mem_addr(addrA),
    .mem_write_data(wdataA), .mem_read_data(rdataA)
  );

  bitcoin_hash_multi #(.NUM_NONCES(3), .OUT_STRIDE(4)) dutB (
    .clk(clk), .reset_n(reset_n), .start(startB), .message_addr(msgB), .output_addr(outB), .nonce_base(baseB),
`ifdef BITCOIN_TARGET_EN
    .target(targetB), .found(foundB), .found_nonce(foundNonceB),
`endif
    .done(doneB), .busy(busyB), .mem_clk(memClkB), .mem_we(weB), .mem_addr(addrB),
    .mem_write_data(wdataB), .mem_read_data(rdataB)
  );

  sha256_block u_shaUnit (
    .clk(clk), .reset_n(reset_n), .start(shaStart), .h_in(shaH), .w_in(shaW), .done(shaDone), .h_out(shaOut)
  );

  // Memory stand-ins: the header is readable at the message address with one
  // cycle of latency; writes are logged mid-cycle for later checking.
  assign offA = addrA - msgA;
  assign offB = addrB - msgB;

  always @(posedge clk) begin
    rdataA <= (offA < 16'd19) ? hdr[offA[4:0]] : 32'h0;
    rdataB <= (offB < 16'd19) ? hdr[offB[4:0]] : 32'h0;
  end

  always @(negedge clk) begin
    if (weA) begin
      logAddrA.push_back(addrA);
      logDataA.push_back(wdataA);
    end
    if (weB) begin
      logAddrB.push_back(addrB);
      logDataB.push_back(wdataB);
    end
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression with a full 64-word schedule.
  function automatic hash_t modelCompress(input hash_t hIn, input block_t blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    hash_t r;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    a = hIn[0]; b = hIn[1]; c = hIn[2]; d = hIn[3];
    e = hIn[4]; f = hIn[5]; g = hIn[6]; h = hIn[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + MK[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = hIn[0] + a; r[1] = hIn[1] + b; r[2] = hIn[2] + c; r[3] = hIn[3] + d;
    r[4] = hIn[4] + e; r[5] = hIn[5] + f; r[6] = hIn[6] + g; r[7] = hIn[7] + h;
    return r;
  endfunction

  function automatic logic [31:0] modelH0(input logic [31:0] nonce);
    hash_t  iv, mid, d2, d3;
    block_t b1, b2, b3;
    for (int i = 0; i < 8; i++) iv[i] = MIV[i];
    for (int i = 0; i < 16; i++) b1[i] = hdr[i];
    mid = modelCompress(iv, b1);
    b2 = '0;
    b2[0] = hdr[16]; b2[1] = hdr[17]; b2[2] = hdr[18]; b2[3] = nonce;
    b2[4] = 32'h80000000; b2[15] = 32'd640;
    d2 = modelCompress(mid, b2);
    b3 = '0;
    for (int i = 0; i < 8; i++) b3[i] = d2[i];
    b3[8] = 32'h80000000; b3[15] = 32'd256;
    d3 = modelCompress(iv, b3);
    return d3[0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [15:0] msg, input logic [15:0] out, input logic [31:0] base);
    @(posedge clk); #1;
    if (which == 0) begin
      msgA = msg; outA = out; baseA = base; startA = 1'b1;
    end else begin
      msgB = msg; outB = out; baseB = base; startB = 1'b1;
    end
    @(posedge clk); #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic waitDone(input int which, input int maxCycles);
    int n;
    n = 0;
    while (((which == 0) ? doneA : doneB) !== 1'b1 && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput($sformatf("dut%0d run completes in budget", which), 32'(n < maxCycles), 32'd1);
  endtask

  task automatic checkRun(input int which, input int first, input logic [15:0] out, input int stride,
                          input logic [31:0] base, input int n);
    int          cnt;
    logic [15:0] expAddr;
    logic [31:0] nonce;
    cnt = (which == 0) ? logAddrA.size() - first : logAddrB.size() - first;
    checkOutput($sformatf("dut%0d write count", which), cnt, n);
    for (int i = 0; i < n && i < cnt; i++) begin
      expAddr = out + 16'(i * stride);
      nonce   = base + 32'(i);
      checkOutput($sformatf("dut%0d wr%0d addr", which, i),
                  (which == 0) ? 32'(logAddrA[first+i]) : 32'(logAddrB[first+i]), 32'(expAddr));
      checkOutput($sformatf("dut%0d wr%0d H0 nonce %h", which, i, nonce),
                  (which == 0) ? logDataA[first+i] : logDataB[first+i], modelH0(nonce));
    end
  endtask

  initial begin
    int n, firstA, firstB;
    reset_n = 1'b0;
    startA = 1'b0; msgA = '0; outA = '0; baseA = '0;
    startB = 1'b0; msgB = '0; outB = '0; baseB = '0;
`ifdef BITCOIN_TARGET_EN
    targetA = '0; targetB = '0;
`endif
    shaStart = 1'b0; shaH = '0; shaW = '0;
    for (int k = 0; k < 19; k++) hdr[k] = (32'h9E3779B9 * 32'(k + 1)) ^ 32'h01234567;

    repeat (3) @(posedge clk); #1;
    checkOutput("reset done", doneA, 0);
    checkOutput("reset busy", busyA, 0);
    checkOutput("reset mem_we", weA, 0);
    checkOutput("reset mem_addr", addrA, 0);
    checkOutput("reset mem_write_data", wdataA, 0);
    checkOutput("reset dutB busy", busyB, 0);
    @(negedge clk); reset_n = 1'b1;

    @(posedge clk); #1;
    checkOutput("mem_clk high", memClkA, clk);
    @(negedge clk); #1;
    checkOutput("mem_clk low", memClkA, clk);

    // Compressor alone on the padded "abc" block
    for (int i = 0; i < 8; i++) shaH[i] = MIV[i];
    shaW = '0;
    shaW[0] = 32'h61626380;
    shaW[15] = 32'h00000018;
    @(posedge clk); #1;
    shaStart = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      shaStart = 1'b0;
      n++;
      if (shaDone) break;
    end
    checkOutput("sha latency", n, 65);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("sha abc h_out[%0d]", i), shaOut[i], ABC[i]);
    @(posedge clk); #1;
    checkOutput("sha done is a pulse", shaDone, 0);

    // Full 16-nonce run, plus a start while busy that must be ignored
    firstA = logAddrA.size();
    applyStimulus(0, 16'h0000, 16'h0100, 32'h0);
    checkOutput("busy after start", busyA, 1);
    checkOutput("done cleared by start", doneA, 0);
    repeat (30) @(posedge clk); #1;
    baseA = 32'hDEAD0000; outA = 16'h0500; startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    waitDone(0, 4000);
    checkRun(0, firstA, 16'h0100, 1, 32'h0, 16);
    repeat (5) @(posedge clk); #1;
    checkOutput("done held", doneA, 1);
    checkOutput("busy low after run", busyA, 0);
    checkOutput("mem_we low after run", weA, 0);
`ifdef BITCOIN_TARGET_EN
    checkOutput("found stays low with target 0", foundA, 0);
`endif

    // Stride 4 with output address wrap
    firstB = logAddrB.size();
    applyStimulus(1, 16'h0040, 16'hFFF8, 32'h10000000);
    waitDone(1, 1500);
    checkRun(1, firstB, 16'hFFF8, 4, 32'h10000000, 3);

    // Nonce wrap past 0xFFFFFFFF
    firstB = logAddrB.size();
    applyStimulus(1, 16'h0040, 16'h0200, 32'hFFFFFFFF);
    waitDone(1, 1500);
    checkRun(1, firstB, 16'h0200, 4, 32'hFFFFFFFF, 3);

    // Reset in P2 of nonce 5, then a clean run
    firstA = logAddrA.size();
    applyStimulus(0, 16'h0000, 16'h0100, 32'h0);
    n = 0;
    while (logAddrA.size() - firstA < 5 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("writes before reset", logAddrA.size() - firstA, 5);
    repeat (20) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset busy", busyA, 0);
    checkOutput("async reset done", doneA, 0);
    checkOutput("async reset mem_we", weA, 0);
    checkOutput("async reset mem_addr", addrA, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    repeat (200) @(posedge clk); #1;
    checkOutput("no writes after reset", logAddrA.size() - firstA, 5);
    checkOutput("idle after reset", busyA, 0);
    firstA = logAddrA.size();
    applyStimulus(0, 16'h0000, 16'h0300, 32'h7);
    waitDone(0, 4000);
    checkRun(0, firstA, 16'h0300, 1, 32'h7, 16);

`ifdef BITCOIN_TARGET_EN
    // Target that every hash beats: single write, then stop
    targetA = 32'hFFFFFFFF;
    firstA = logAddrA.size();
    applyStimulus(0, 16'h0000, 16'h0100, 32'h20);
    waitDone(0, 4000);
    checkRun(0, firstA, 16'h0100, 1, 32'h20, 1);
    checkOutput("found set", foundA, 1);
    checkOutput("found_nonce", foundNonceA, 32'h20);
    targetA = 32'h0;
    firstA = logAddrA.size();
    applyStimulus(0, 16'h0000, 16'h0100, 32'h40);
    checkOutput("found cleared by start", foundA, 0);
    waitDone(0, 4000);
    checkRun(0, firstA, 16'h0100, 1, 32'h40, 16);
    checkOutput("found low with target 0", foundA, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
